multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle SimpleCPU datapath, with memory wait timeout and trap.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALUOp,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic             TIMEOUT_EN  = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0]       trap_cause_reg, trap_cause_next;
    logic             in_wait_state;
    logic             timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            wait_cnt_reg   <= '0;
            trap_cause_reg <= 2'b00;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            trap_cause_reg <= trap_cause_next;
        end
    end

    // mem_ready on the limit cycle still completes the access, so it masks the timeout.
    assign in_wait_state = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                           (state_reg == S_MEM_WR);
    assign timeout       = TIMEOUT_EN && in_wait_state && !mem_ready &&
                           (wait_cnt_reg == TIMEOUT_VAL);
    assign wait_cnt_next = (in_wait_state && !mem_ready && !timeout) ?
                           wait_cnt_reg + CNT_W'(1) : '0;

    always_comb begin
        state_next      = state_reg;
        trap_cause_next = trap_cause_reg;
        pc_write        = 1'b0;
        pc_write_cond   = 1'b0;
        pc_source       = 2'b00;
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        ALUOp           = 2'b00;
        trap            = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next      = S_TRAP;
                    trap_cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_next = S_EXEC_R;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next      = S_TRAP;
                        trap_cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout) begin
                    state_next      = S_TRAP;
                    trap_cause_next = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next      = S_TRAP;
                    trap_cause_next = CAUSE_TIMEOUT;
                end
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                ALUOp      = 2'b10;
                state_next = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                ALUOp         = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign state      = state_reg;
    assign trap_cause = trap_cause_reg;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    // Only normally completed instructions retire; trap and run-start entries into FETCH do not.
    logic        retire;
    logic [31:0] retired_cnt_reg;

    assign retire = (state_next == S_FETCH) &&
                    (state_reg inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP});

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_reg <= 32'd0;
        end else if (retire) begin
            retired_cnt_reg <= retired_cnt_reg + 32'd1;
        end
    end

    assign retired_cnt = retired_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: reset, table-driven instruction vectors,
// randomized instruction stream against a per-instruction cycle-trace model, reset mid-store.
module tb_multicycle_ctrl;

    localparam int TO = 3;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                           ST_MEM_ADDR = 4'd3, ST_MEM_RD = 4'd4, ST_MEM_WB = 4'd5,
                           ST_MEM_WR = 4'd6, ST_EXEC_R = 4'd7, ST_R_WB = 4'd8,
                           ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_TRAP = 4'd11;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010;

    logic       clk = 1'b0;
    logic       rst, run, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, trap;
    logic [1:0] pc_source, alu_src_b, ALUOp, trap_cause;
    logic [3:0] state;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [31:0] retired_cnt;
`endif

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp), .trap(trap),
        .trap_cause(trap_cause), .state(state)
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [16:0] dut_ctrl;
    assign dut_ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                       ALUOp, trap};

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  exp_cause;
    logic [31:0] exp_retired;

    typedef struct {
        logic [3:0] st;
        logic       mr_care;
        logic       mr;
        logic [1:0] cause;
    } trace_t;
    trace_t trace[$];

    typedef struct {
        logic [5:0] op;
        int         fw;
        int         mw;
        int         cycles;
        logic [1:0] cause;
    } vec_t;

    // Control word each state must present, straight from the state/output table.
    function automatic logic [16:0] spec_ctrl(input logic [3:0] st, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, trp;
        logic [1:0] psrc, asb, aop;
        {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, trp} = '0;
        {psrc, asb, aop} = '0;
        case (st)
            ST_FETCH:    begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            ST_DECODE:   asb = 2'b11;
            ST_MEM_ADDR: begin asa = 1; asb = 2'b10; end
            ST_MEM_RD:   begin mrd = 1; iord = 1; end
            ST_MEM_WB:   begin rw = 1; m2r = 1; end
            ST_MEM_WR:   begin mwr = 1; iord = 1; end
            ST_EXEC_R:   begin asa = 1; aop = 2'b10; end
            ST_R_WB:     begin rw = 1; rdst = 1; end
            ST_BRANCH:   begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            ST_JUMP:     begin pcw = 1; psrc = 2'b10; end
            ST_TRAP:     trp = 1;
            default:     ;
        endcase
        return {pcw, pcwc, psrc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, trp};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle(input logic [3:0] exp_st);
        chk("state", 32'(state), 32'(exp_st));
        chk("ctrl", 32'(dut_ctrl), 32'(spec_ctrl(exp_st, mem_ready)));
        chk("trap_cause", 32'(trap_cause), 32'(exp_cause));
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        chk("retired_cnt", retired_cnt, exp_retired);
`endif
    endtask

    task automatic push(input logic [3:0] st, input logic care, input logic mr,
                        input logic [1:0] cause);
        trace_t e;
        e.st = st; e.mr_care = care; e.mr = mr; e.cause = cause;
        trace.push_back(e);
    endtask

    // A memory access that becomes ready after 'waits' idle cycles, or traps at the limit.
    task automatic push_access(input logic [3:0] st, input int waits, output bit trapped);
        trapped = 0;
        for (int i = 0; i <= TO; i++) begin
            if (i == waits) begin
                push(st, 1, 1, 2'b00);
                return;
            end
            push(st, 1, 0, 2'b00);
            if (i == TO) begin
                push(ST_TRAP, 0, 0, 2'b10);
                trapped = 1;
                return;
            end
        end
    endtask

    task automatic build_trace(input logic [5:0] op, input int fw, input int mw);
        bit t;
        trace.delete();
        push_access(ST_FETCH, fw, t);
        if (t) return;
        push(ST_DECODE, 0, 0, 2'b00);
        case (op)
            OP_R:   begin push(ST_EXEC_R, 0, 0, 2'b00); push(ST_R_WB, 0, 0, 2'b00); end
            OP_LW:  begin
                push(ST_MEM_ADDR, 0, 0, 2'b00);
                push_access(ST_MEM_RD, mw, t);
                if (!t) push(ST_MEM_WB, 0, 0, 2'b00);
            end
            OP_SW:  begin push(ST_MEM_ADDR, 0, 0, 2'b00); push_access(ST_MEM_WR, mw, t); end
            OP_BEQ: push(ST_BRANCH, 0, 0, 2'b00);
            OP_J:   push(ST_JUMP, 0, 0, 2'b00);
            default: push(ST_TRAP, 0, 0, 2'b01);
        endcase
    endtask

    // Starts with the DUT in FETCH just after a clock edge; leaves it one edge past the trace.
    task automatic run_trace(input logic [5:0] op, output int dut_len);
        dut_len = 0;
        opcode  = op;
        foreach (trace[i]) begin
            mem_ready = trace[i].mr_care ? trace[i].mr : 1'($urandom_range(0, 1));
            #1;
            if (trace[i].st == ST_TRAP) exp_cause = trace[i].cause;
            check_cycle(trace[i].st);
            if (state != ST_FETCH) dut_len = i + 1;
            @(posedge clk);
            #1;
        end
        if (trace[trace.size()-1].st != ST_TRAP) exp_retired = exp_retired + 32'd1;
    endtask

    vec_t vecs[12];
    int   len;

    initial begin
        vecs[0]  = '{OP_R,     0, 0, 4, 2'b00};
        vecs[1]  = '{OP_LW,    0, 3, 8, 2'b00};
        vecs[2]  = '{OP_SW,    0, 2, 6, 2'b00};
        vecs[3]  = '{OP_BEQ,   0, 0, 3, 2'b00};
        vecs[4]  = '{OP_J,     1, 0, 4, 2'b00};
        vecs[5]  = '{6'h3F,    0, 0, 3, 2'b01};
        vecs[6]  = '{OP_R,     5, 0, 5, 2'b10};
        vecs[7]  = '{OP_LW,    3, 0, 8, 2'b10};
        vecs[8]  = '{OP_LW,    0, 7, 8, 2'b10};
        vecs[9]  = '{6'b000001, 0, 0, 3, 2'b01};
        vecs[10] = '{OP_SW,    0, 4, 8, 2'b10};
        vecs[11] = '{OP_SW,    2, 3, 9, 2'b10};

        rst = 1; run = 0; opcode = 6'd0; mem_ready = 0;
        exp_cause = 2'b00; exp_retired = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        check_cycle(ST_IDLE);
        repeat (3) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
            check_cycle(ST_IDLE);
        end
        run = 1;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            build_trace(vecs[k].op, vecs[k].fw, vecs[k].mw);
            run_trace(vecs[k].op, len);
            $display("vec %0d op=%b fw=%0d mw=%0d cycles=%0d cause=%b",
                     k, vecs[k].op, vecs[k].fw, vecs[k].mw, len, trap_cause);
            chk("latency", 32'(len), 32'(vecs[k].cycles));
            chk("end_state", 32'(state), 32'(ST_FETCH));
            chk("vec_cause", 32'(trap_cause), 32'(vecs[k].cause));
        end

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            int fw, mw;
            case ($urandom_range(0, 5))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_J;
                default: op = 6'($urandom);
            endcase
            fw = $urandom_range(0, 5);
            mw = $urandom_range(0, 5);
            build_trace(op, fw, mw);
            run_trace(op, len);
            $display("rnd %0d op=%b fw=%0d mw=%0d cycles=%0d", n, op, fw, mw, len);
        end

        // Reset while a store waits in MEM_WR.
        opcode = OP_SW; mem_ready = 1;
        #1; check_cycle(ST_FETCH);
        @(posedge clk); #1;
        mem_ready = 0;
        #1; check_cycle(ST_DECODE);
        @(posedge clk); #1;
        #1; check_cycle(ST_MEM_ADDR);
        @(posedge clk); #1;
        #1; check_cycle(ST_MEM_WR);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; run = 0;
        exp_cause = 2'b00; exp_retired = 32'd0;
        #1;
        check_cycle(ST_IDLE);
        chk("mem_write_after_rst", 32'(mem_write), 32'd0);
        $display("reset in MEM_WR: state=%0d mem_write=%b", state, mem_write);
        run = 1;
        @(posedge clk); #1;
        build_trace(OP_BEQ, 0, 0); run_trace(OP_BEQ, len);
        build_trace(OP_J, 0, 0);   run_trace(OP_J, len);
        build_trace(OP_R, 0, 0);   run_trace(OP_R, len);
        #1;
        check_cycle(ST_FETCH);
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        chk("retired_three", retired_cnt, 32'd3);
        $display("retired after beq/j/R: %0d", retired_cnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
